// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch types, fetch states and instruction fields.
// Used by both the decoder and the fetch unit.
package cpu_pkg;

  localparam logic [1:0] BR_EQ = 2'd0;
  localparam logic [1:0] BR_GT = 2'd1;
  localparam logic [1:0] BR_GE = 2'd2;
  localparam logic [1:0] BR_NE = 2'd3;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int IMM_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int TGT_LSB = 0;
  localparam int TGT_MSB = 25;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluation from ALU flags.
// Purely combinational.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [1:0] branch_type_i,
  input  logic       zero_i,
  input  logic       neg_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    unique case (branch_type_i)
      BR_EQ: taken_o = zero_i;
      BR_GT: taken_o = !zero_i && !neg_i;
      BR_GE: taken_o = !neg_i;
      BR_NE: taken_o = !zero_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Registered fetch stage: PC, imem req/ack handshake, next-PC select.
// Instruction is held for execute until it signals ready.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              branch_i,
  input  logic [1:0]        branch_type_i,
  input  logic              jump_i,
  input  logic              zero_i,
  input  logic              neg_i
);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_o;
  logic [31:0]       r_instr;
  logic              w_capture;
  logic              w_advance;
  logic              w_taken;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_jmp_tgt;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_next_pc;

  branch_cond_eval u_cond (
    .branch_type_i (branch_type_i),
    .zero_i        (zero_i),
    .neg_i         (neg_i),
    .taken_o       (w_taken)
  );

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_capture    = imem_ack_i;
        w_next_state = imem_ack_i ? HOLD : WAIT;
      end
      WAIT: begin
        w_capture = imem_ack_i;
        if (imem_ack_i) w_next_state = HOLD;
      end
      HOLD: begin
        w_advance = instr_ready_i;
        if (instr_ready_i) w_next_state = FETCH;
      end
      default: w_next_state = FETCH;
    endcase
  end

  assign w_pc4     = r_pc_o + 32'd4;
  assign w_jmp_tgt = {w_pc4[31:28], r_instr[TGT_MSB:TGT_LSB], 2'b00};
  assign w_br_off  = {{14{r_instr[IMM_MSB]}},
                      r_instr[IMM_MSB:IMM_LSB], 2'b00};
  assign w_br_tgt  = w_pc4 + w_br_off;

  // Jump outranks a taken branch when both are flagged.
  always_comb begin
    w_next_pc = w_pc4;
    priority case (1'b1)
      jump_i:              w_next_pc = w_jmp_tgt;
      branch_i && w_taken: w_next_pc = w_br_tgt;
      default:             w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_pc_o  <= RESET_PC;
      r_instr <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_instr <= imem_data_i;
        r_pc_o  <= r_pc;
      end
      if (w_advance) r_pc <= w_next_pc;
    end
  end

  assign imem_req_o    = (r_state == FETCH) || (r_state == WAIT);
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = (r_state == HOLD);
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_o;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a next-PC reference model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        rdy;
  logic        br;
  logic [1:0]  bt;
  logic        jp;
  logic        z;
  logic        n;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ack_i    (ack),
    .imem_data_i   (data),
    .instr_o       (instr),
    .pc_o          (pc),
    .instr_valid_o (valid),
    .instr_ready_i (rdy),
    .branch_i      (br),
    .branch_type_i (bt),
    .jump_i        (jp),
    .zero_i        (z),
    .neg_i         (n)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_next(
    input logic [31:0] cur, input logic [31:0] word,
    input logic b, input logic [1:0] typ, input logic j,
    input logic zf, input logic nf);
    logic [31:0] pc4;
    logic        tk;
    int          imm;
    pc4 = cur + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    case (typ)
      2'd0:    tk = zf;
      2'd1:    tk = !zf && !nf;
      2'd2:    tk = !nf;
      default: tk = !zf;
    endcase
    imm = int'($signed(word[15:0]));
    if (b && tk) return pc4 + 32'(imm * 4);
    return pc4;
  endfunction

  task automatic scramble();
    br = 1'($urandom);
    bt = 2'($urandom);
    jp = 1'($urandom);
    z  = 1'($urandom);
    n  = 1'($urandom);
  endtask

  task automatic run_instr(input logic [31:0] word, input int ack_dly,
                           input int rdy_dly, input logic b,
                           input logic [1:0] typ, input logic j,
                           input logic zf, input logic nf);
    chk("fetch_req", 32'(req), 32'd1);
    chk("fetch_addr", addr, exp_pc);
    chk("fetch_valid", 32'(valid), 32'd0);
    for (int k = 0; k < ack_dly; k++) begin
      ack  = 1'b0;
      data = $urandom;
      rdy  = 1'($urandom);
      scramble();
      @(negedge clk);
      chk("wait_req", 32'(req), 32'd1);
      chk("wait_addr", addr, exp_pc);
      chk("wait_valid", 32'(valid), 32'd0);
    end
    ack  = 1'b1;
    data = word;
    rdy  = 1'($urandom);
    @(negedge clk);
    ack  = 1'b0;
    chk("hold_valid", 32'(valid), 32'd1);
    chk("hold_req", 32'(req), 32'd0);
    chk("hold_instr", instr, word);
    chk("hold_pc", pc, exp_pc);
    for (int k = 0; k < rdy_dly; k++) begin
      rdy  = 1'b0;
      ack  = 1'($urandom);
      data = $urandom;
      scramble();
      @(negedge clk);
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_instr", instr, word);
      chk("stall_addr", addr, exp_pc);
    end
    ack = 1'b0;
    rdy = 1'b1;
    br  = b;
    bt  = typ;
    jp  = j;
    z   = zf;
    n   = nf;
    @(negedge clk);
    rdy = 1'b0;
    scramble();
    exp_pc = model_next(exp_pc, word, b, typ, j, zf, nf);
    chk("after_valid", 32'(valid), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    ack  = 1'b0;
    data = 32'h0;
    rdy  = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    rst    = 1'b0;
    exp_pc = 32'h0;

    // sequential fetches 0x0, 0x4, 0x8, then 0xC
    for (int i = 0; i < 4; i++)
      run_instr($urandom, 1, 1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("at_10", exp_pc, 32'h10);
    run_instr(32'h1000_FFFE, 1, 1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("beq_taken", exp_pc, 32'h0C);
    run_instr($urandom, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1000_FFFE, 1, 1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("beq_not", exp_pc, 32'h14);
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    run_instr(32'h1400_FFFE, 1, 1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("bne_taken", exp_pc, 32'h0C);

    // branch back to the top of the address space, then wrap
    run_instr(32'h1000_FFFB, 0, 0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("at_top", exp_pc, 32'hFFFF_FFFC);
    run_instr($urandom, 1, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap", exp_pc, 32'h0);
    run_instr(32'h1000_FFFE, 0, 1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    run_instr(32'h1000_0008, 1, 0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    chk("gt_neg", exp_pc, 32'h0);
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    run_instr(32'h0BFF_0100, 1, 1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("jump_wins", exp_pc, 32'h0FFC_0400);

    // long memory latency and long execute stall
    run_instr($urandom, 5, 4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // reset lands in WAIT together with an ack
    chk("pre_rst_req", 32'(req), 32'd1);
    ack = 1'b0;
    @(negedge clk);
    chk("in_wait", 32'(req), 32'd1);
    rst  = 1'b1;
    ack  = 1'b1;
    data = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    exp_pc = 32'h0;
    chk("rst_wait_instr", instr, 32'h0);
    chk("rst_wait_valid", 32'(valid), 32'd0);
    chk("rst_wait_pc", pc, 32'h0);

    for (int i = 0; i < 200; i++)
      run_instr($urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
    chk("final_addr", addr, exp_pc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
